// File: rtl/rtc_write_sequencer.sv
// rtc_write_sequencer
// Walks the RTC register map (0x21..0x28, 0x41..0x43). Each register slot gets
// an address phase and then a data phase with a write strobe, and each phase is
// held for HOLD cycles. The write bytes come from the settings bank, which the
// slot index selects. bus_own tells the read sequencer to release the shared bus.
// All outputs are registered. Each one is computed from the next-state values,
// so it lines up with the state it describes.

module rtc_write_sequencer #(
  parameter logic [11:0] HOLD = 12'h04A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       escribe,
  input  logic [7:0] data_in,
  output logic [3:0] slot,
  output logic [7:0] address,
  output logic [7:0] data_out,
  output logic       wr_en,
  output logic       bus_own,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_SLOT = 4'd10;

  // Maps a slot to its RTC register. Slots that cannot be reached map to 8'h00.
  function automatic logic [7:0] slot_to_addr(input logic [3:0] s);
    logic [7:0] a;
    case (s)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd6:    a = 8'h27;
      4'd7:    a = 8'h28;
      4'd8:    a = 8'h41;
      4'd9:    a = 8'h42;
      4'd10:   a = 8'h43;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [11:0] cnt_r;
  logic [11:0] cnt_nxt_s;
  logic [3:0]  slot_r;
  logic [3:0]  slot_nxt_s;
  logic        escribe_q_r;
  logic        start_s;
  logic        active_nxt_s;
  logic [7:0]  data_nxt_s;
  logic [7:0]  address_r;
  logic [7:0]  data_out_r;
  logic        wr_en_r;
  logic        bus_own_r;
  logic        busy_r;
  logic        done_r;

  assign start_s      = escribe & ~escribe_q_r;
  assign active_nxt_s = (state_nxt_s == ST_ADDR) || (state_nxt_s == ST_DATA);

  // Next-state logic for the phase machine. It covers the counter, the slot
  // and the byte being driven.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    slot_nxt_s  = slot_r;
    data_nxt_s  = data_out_r;
    case (state_r)
      ST_IDLE: begin
        slot_nxt_s = 4'd0;
        data_nxt_s = 8'h00;
        if (start_s) begin
          state_nxt_s = ST_ADDR;
          cnt_nxt_s   = 12'd1;
        end else begin
          cnt_nxt_s   = 12'd0;
        end
      end
      ST_ADDR: begin
        if (slot_r > LAST_SLOT) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 12'd0;
          slot_nxt_s  = 4'd0;
          data_nxt_s  = 8'h00;
        end else if (cnt_r >= HOLD) begin
          // The settings bank already presents this slot's byte, so capture it now.
          state_nxt_s = ST_DATA;
          cnt_nxt_s   = 12'd1;
          data_nxt_s  = data_in;
        end else begin
          cnt_nxt_s   = cnt_r + 12'd1;
          data_nxt_s  = 8'h00;
        end
      end
      ST_DATA: begin
        if (slot_r > LAST_SLOT) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 12'd0;
          slot_nxt_s  = 4'd0;
          data_nxt_s  = 8'h00;
        end else if (cnt_r >= HOLD) begin
          data_nxt_s = 8'h00;
          if (slot_r < LAST_SLOT) begin
            state_nxt_s = ST_ADDR;
            cnt_nxt_s   = 12'd1;
            slot_nxt_s  = slot_r + 4'd1;
          end else begin
            state_nxt_s = ST_DONE;
            cnt_nxt_s   = 12'd0;
          end
        end else begin
          cnt_nxt_s = cnt_r + 12'd1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 12'd0;
        slot_nxt_s  = 4'd0;
        data_nxt_s  = 8'h00;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 12'd0;
        slot_nxt_s  = 4'd0;
        data_nxt_s  = 8'h00;
      end
    endcase
  end

  // State, counter and edge-detect registers. Reset aborts a sequence outright.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 12'd0;
      slot_r      <= 4'd0;
      escribe_q_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      slot_r      <= slot_nxt_s;
      escribe_q_r <= escribe;
    end
  end

  // Output registers, loaded from the next state so they change together with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      address_r  <= 8'h00;
      data_out_r <= 8'h00;
      wr_en_r    <= 1'b0;
      bus_own_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      address_r  <= active_nxt_s ? slot_to_addr(slot_nxt_s) : 8'h00;
      data_out_r <= (state_nxt_s == ST_DATA) ? data_nxt_s : 8'h00;
      wr_en_r    <= (state_nxt_s == ST_DATA);
      bus_own_r  <= active_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
      done_r     <= (state_nxt_s == ST_DONE);
    end
  end

  assign slot     = slot_r;
  assign address  = address_r;
  assign data_out = data_out_r;
  assign wr_en    = wr_en_r;
  assign bus_own  = bus_own_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// tb_rtc_write_sequencer
// Directed bench with two instances: one with HOLD=4 and one with HOLD=1.
// The settings bank is modelled as data_in = 8'hA0 + slot.

module tb_rtc_write_sequencer;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } slot_rec_t;

  typedef struct {
    logic        reset;
    logic        escribe;
    logic [23:0] exp;
  } idle_vec_t;

  logic       clk;
  logic       reset;
  logic       esc4;
  logic       esc1;
  logic [7:0] din4;
  logic [7:0] din1;
  logic [3:0] slot4, slot1;
  logic [7:0] addr4, addr1, dout4, dout1;
  logic       wr4, wr1, own4, own1, busy4, busy1, done4, done1;

  int n_vec;
  int n_bad;

  slot_rec_t slot_tab [11];
  idle_vec_t idle_tab [8];

  rtc_write_sequencer #(.HOLD(12'd4)) dut4 (
    .clk(clk), .reset(reset), .escribe(esc4), .data_in(din4),
    .slot(slot4), .address(addr4), .data_out(dout4), .wr_en(wr4),
    .bus_own(own4), .busy(busy4), .done(done4)
  );

  rtc_write_sequencer #(.HOLD(12'd1)) dut1 (
    .clk(clk), .reset(reset), .escribe(esc1), .data_in(din1),
    .slot(slot1), .address(addr1), .data_out(dout1), .wr_en(wr1),
    .bus_own(own1), .busy(busy1), .done(done1)
  );

  assign din4 = 8'hA0 + {4'h0, slot4};
  assign din1 = 8'hA0 + {4'h0, slot1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle {slot, address, data_out, wr_en, bus_own, busy, done}.
  function automatic logic [23:0] got(input int h);
    if (h == 4) return {slot4, addr4, dout4, wr4, own4, busy4, done4};
    else        return {slot1, addr1, dout1, wr1, own1, busy1, done1};
  endfunction

  // Expected bundle n clock edges after the edge that sampled the escribe rise.
  function automatic logic [23:0] expect_at(input int h, input int n);
    int k, s;
    logic ph;
    logic [3:0] s4;
    if (n < 1 || n > 22 * h + 1) return 24'h0;
    if (n == 22 * h + 1) return {4'd10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    k  = n - 1;
    s  = k / (2 * h);
    ph = ((k % (2 * h)) >= h);
    s4 = s[3:0];
    return {s4, slot_tab[s].addr, (ph ? slot_tab[s].data : 8'h00), ph, 1'b1, 1'b1, 1'b0};
  endfunction

  task automatic check(input string name, input int idx, input logic [23:0] act,
                       input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got slot=%0d addr=%h dout=%h wr=%b own=%b busy=%b done=%b, want slot=%0d addr=%h dout=%h wr=%b own=%b busy=%b done=%b",
               name, idx, act[23:20], act[19:12], act[11:4], act[3], act[2], act[1], act[0],
               exp[23:20], exp[19:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic set_esc(input int h, input logic v);
    if (h == 4) esc4 = v;
    else        esc1 = v;
  endtask

  // Raise escribe, then check every cycle against the timing model.
  // drop_at and rise_at move escribe after the check of that cycle. rst_at pulls
  // reset low for two edges, and every check after that expects idle outputs.
  task automatic run_seq(input string name, input int h, input int drop_at,
                         input int rise_at, input int rst_at, input int ncyc);
    int dones;
    logic [23:0] exp;
    dones = 0;
    set_esc(h, 1'b1);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (rst_at >= 0 && n > rst_at) exp = 24'h0;
      else                           exp = expect_at(h, n);
      check(name, n, got(h), exp);
      if (got(h) & 24'h1) dones++;
      if (n == drop_at) set_esc(h, 1'b0);
      if (n == rise_at) set_esc(h, 1'b1);
      if (n == rst_at) reset = 1'b0;
      if (rst_at >= 0 && n == rst_at + 2) reset = 1'b1;
    end
    n_vec++;
    if (dones != ((rst_at >= 0) ? 0 : 1)) begin
      n_bad++;
      $display("FAIL %s_done_count: got %0d pulses, want %0d", name, dones,
               (rst_at >= 0) ? 0 : 1);
    end
    set_esc(h, 1'b0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    esc4  = 1'b0;
    esc1  = 1'b0;

    slot_tab[0]  = '{8'h21, 8'hA0};
    slot_tab[1]  = '{8'h22, 8'hA1};
    slot_tab[2]  = '{8'h23, 8'hA2};
    slot_tab[3]  = '{8'h24, 8'hA3};
    slot_tab[4]  = '{8'h25, 8'hA4};
    slot_tab[5]  = '{8'h26, 8'hA5};
    slot_tab[6]  = '{8'h27, 8'hA6};
    slot_tab[7]  = '{8'h28, 8'hA7};
    slot_tab[8]  = '{8'h41, 8'hA8};
    slot_tab[9]  = '{8'h42, 8'hA9};
    slot_tab[10] = '{8'h43, 8'hAA};

    idle_tab[0] = '{1'b0, 1'b0, 24'h0};
    idle_tab[1] = '{1'b0, 1'b0, 24'h0};
    idle_tab[2] = '{1'b0, 1'b0, 24'h0};
    idle_tab[3] = '{1'b1, 1'b0, 24'h0};
    idle_tab[4] = '{1'b1, 1'b0, 24'h0};
    idle_tab[5] = '{1'b1, 1'b0, 24'h0};
    idle_tab[6] = '{1'b1, 1'b0, 24'h0};
    idle_tab[7] = '{1'b1, 1'b0, 24'h0};

    // Reset held low for three edges, then released with escribe low.
    for (int i = 0; i < 8; i++) begin
      reset = idle_tab[i].reset;
      esc4  = idle_tab[i].escribe;
      esc1  = idle_tab[i].escribe;
      @(negedge clk);
      check("idle_h4", i, got(4), idle_tab[i].exp);
      check("idle_h1", i, got(1), idle_tab[i].exp);
    end

    // Full sequence with a one-cycle escribe pulse.
    run_seq("seq_h4", 4, 1, -1, -1, 22 * 4 + 4);
    // escribe held high through the sequence and beyond, so only one sequence runs.
    run_seq("hold_h4", 4, -1, -1, -1, 22 * 4 + 12);
    // After escribe drops and rises again, a second sequence runs.
    run_seq("again_h4", 4, 1, -1, -1, 22 * 4 + 4);
    // A second rising edge of escribe during slot 5 is ignored.
    run_seq("edge5_h4", 4, 1, 43, -1, 22 * 4 + 6);
    // Reset during the DATA phase of slot 3 aborts the sequence with no done pulse.
    run_seq("rst3_h4", 4, 1, -1, 30, 40);
    // The next start begins again at 8'h21.
    run_seq("restart_h4", 4, 1, -1, -1, 22 * 4 + 4);
    // With HOLD=1, each phase lasts one cycle.
    run_seq("seq_h1", 1, 1, -1, -1, 22 * 1 + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
